lu_row_store: RTL and testbench

//  Matrix row store directly upstream of the lu engine. Loads a SIZE x SIZE complex matrix from the host row by row.

---
 rtl/lu_pkg.sv | 19 +
 rtl/lu_row_mem.sv | 52 +++++
 rtl/lu_row_store.sv | 164 ++++++++++++++++
 tb/tb_lu_row_store.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared types and FSM state encoding for the lu row store
package lu_pkg;

  localparam int LU_SIZE  = 16;
  localparam int LU_WIDTH = 64;

  typedef logic [2*LU_WIDTH-1:0]        elem_t;
  typedef elem_t [LU_SIZE-1:0]          row_t;
  typedef logic [$clog2(LU_SIZE)-1:0]   addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN
  } lu_store_state_e;

endpackage

// File: rtl/lu_row_mem.sv
// rtl/lu_row_mem.sv - SIZE-row register array, one write port, two registered read ports
// Optional LU_ROW_STORE_BYPASS_EN: same-cycle write forwards to the lu read port.
module lu_row_mem #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en,
  input  logic [$clog2(SIZE)-1:0]   wr_addr,
  input  logic [SIZE*2*WIDTH-1:0]   wr_data,
  input  logic                      lu_rd_en,
  input  logic [$clog2(SIZE)-1:0]   lu_rd_addr,
  output logic [SIZE*2*WIDTH-1:0]   lu_rd_data,
  input  logic                      dr_rd_en,
  input  logic [$clog2(SIZE)-1:0]   dr_rd_addr,
  output logic [SIZE*2*WIDTH-1:0]   dr_rd_data
);

  localparam int RW = SIZE*2*WIDTH;

  logic [RW-1:0] mem_q [SIZE];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_rd_data <= '0;
    end else if (lu_rd_en) begin
`ifdef LU_ROW_STORE_BYPASS_EN
      if (wr_en && (wr_addr == lu_rd_addr)) lu_rd_data <= wr_data;
      else                                  lu_rd_data <= mem_q[lu_rd_addr];
`else
      lu_rd_data <= mem_q[lu_rd_addr];
`endif
    end
  end

  // The drain port always forwards: the last RUN write may land on row 0
  // in the same edge that prefetches row 0 for the host.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dr_rd_data <= '0;
    end else if (dr_rd_en) begin
      if (wr_en && (wr_addr == dr_rd_addr)) dr_rd_data <= wr_data;
      else                                  dr_rd_data <= mem_q[dr_rd_addr];
    end
  end

endmodule

// File: rtl/lu_row_store.sv
// rtl/lu_row_store.sv - host load / lu service / host drain row store for the lu engine
// Build option LU_ROW_STORE_BYPASS_EN selects write-to-read forwarding on the lu port.
module lu_row_store
  import lu_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [SIZE*2*WIDTH-1:0]   host_row_i,
  input  logic                      host_row_valid_i,
  output logic                      host_row_ready_o,
  input  logic                      host_start_i,
  input  logic                      flush_i,
  output logic [SIZE*2*WIDTH-1:0]   out_row_o,
  output logic                      out_row_valid_o,
  input  logic                      out_row_ready_i,
  output logic                      done_o,
  output logic                      lu_start_o,
  output logic                      lu_flush_o,
  input  logic                      lu_busy_i,
  input  logic [$clog2(SIZE)-1:0]   lu_rd_addr_i,
  input  logic                      lu_rd_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0]   lu_row_o,
  output logic                      lu_row_valid_o,
  output logic [$clog2(SIZE)-1:0]   lu_row_addr_o,
  input  logic [SIZE*2*WIDTH-1:0]   lu_wr_row_i,
  input  logic                      lu_wr_valid_i,
  input  logic [$clog2(SIZE)-1:0]   lu_wr_addr_i,
  output logic                      lu_wr_ready_o
);

  localparam int AW = $clog2(SIZE);
  localparam int RW = SIZE*2*WIDTH;
  localparam logic [AW-1:0] LAST = AW'(SIZE-1);

  lu_store_state_e state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            seen_q, seen_d;
  logic            done_q, done_d;
  logic            lu_row_valid_q;
  logic [AW-1:0]   lu_row_addr_q;

  logic            host_wr, lu_wr, lu_rd_en, dr_rd_en;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_wr_addr;
  logic [RW-1:0]   mem_wr_data;

  // A flush cycle never touches memory and never issues a read.
  assign host_wr  = (state_q == LOAD) && host_row_valid_i   && !flush_i;
  assign lu_wr    = (state_q == RUN)  && lu_wr_valid_i      && !flush_i;
  assign lu_rd_en = (state_q == RUN)  && lu_rd_addr_valid_i && !flush_i;

  assign mem_wr_en   = host_wr || lu_wr;
  assign mem_wr_addr = (state_q == LOAD) ? cnt_q      : lu_wr_addr_i;
  assign mem_wr_data = (state_q == LOAD) ? host_row_i : lu_wr_row_i;

  // Prefetch the row the host will see next cycle so out_row_o is row[cnt].
  assign dr_rd_en = (state_d == DRAIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host_start_i) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
        LOAD: begin
          if (host_row_valid_i) begin
            if (cnt_q == LAST) begin
              state_d = START;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + AW'(1);
            end
          end
        end
        START: begin
          state_d = RUN;
          seen_d  = 1'b0;
        end
        RUN: begin
          if (lu_busy_i) seen_d = 1'b1;
          if (seen_q && !lu_busy_i) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
        DRAIN: begin
          if (out_row_ready_i) begin
            if (cnt_q == LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + AW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      seen_q         <= 1'b0;
      done_q         <= 1'b0;
      lu_row_valid_q <= 1'b0;
      lu_row_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seen_q         <= seen_d;
      done_q         <= done_d;
      lu_row_valid_q <= lu_rd_en;
      if (lu_rd_en) lu_row_addr_q <= lu_rd_addr_i;
    end
  end

  lu_row_mem #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en      (mem_wr_en),
    .wr_addr    (mem_wr_addr),
    .wr_data    (mem_wr_data),
    .lu_rd_en   (lu_rd_en),
    .lu_rd_addr (lu_rd_addr_i),
    .lu_rd_data (lu_row_o),
    .dr_rd_en   (dr_rd_en),
    .dr_rd_addr (cnt_d),
    .dr_rd_data (out_row_o)
  );

  assign host_row_ready_o = (state_q == LOAD);
  assign lu_start_o       = (state_q == START);
  assign lu_wr_ready_o    = (state_q == RUN);
  assign out_row_valid_o  = (state_q == DRAIN);
  assign lu_flush_o       = flush_i;
  assign done_o           = done_q;
  assign lu_row_valid_o   = lu_row_valid_q;
  assign lu_row_addr_o    = lu_row_addr_q;

endmodule

// File: tb/tb_lu_row_store.sv
// tb/tb_lu_row_store.sv - randomized self-checking bench for lu_row_store (SIZE=4)
module tb_lu_row_store;

  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int AW    = $clog2(SIZE);
  localparam int RW    = SIZE*2*WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [RW-1:0] host_row_i;
  logic          host_row_valid_i, host_row_ready_o, host_start_i, flush_i;
  logic [RW-1:0] out_row_o;
  logic          out_row_valid_o, out_row_ready_i, done_o;
  logic          lu_start_o, lu_flush_o, lu_busy_i;
  logic [AW-1:0] lu_rd_addr_i;
  logic          lu_rd_addr_valid_i;
  logic [RW-1:0] lu_row_o;
  logic          lu_row_valid_o;
  logic [AW-1:0] lu_row_addr_o;
  logic [RW-1:0] lu_wr_row_i;
  logic          lu_wr_valid_i;
  logic [AW-1:0] lu_wr_addr_i;
  logic          lu_wr_ready_o;

  int checks   = 0;
  int failures = 0;
  int done_seen  = 0;
  int start_seen = 0;
  logic [RW-1:0] model [SIZE];

  always #5 clk_i = ~clk_i;

  lu_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .host_row_i         (host_row_i),
    .host_row_valid_i   (host_row_valid_i),
    .host_row_ready_o   (host_row_ready_o),
    .host_start_i       (host_start_i),
    .flush_i            (flush_i),
    .out_row_o          (out_row_o),
    .out_row_valid_o    (out_row_valid_o),
    .out_row_ready_i    (out_row_ready_i),
    .done_o             (done_o),
    .lu_start_o         (lu_start_o),
    .lu_flush_o         (lu_flush_o),
    .lu_busy_i          (lu_busy_i),
    .lu_rd_addr_i       (lu_rd_addr_i),
    .lu_rd_addr_valid_i (lu_rd_addr_valid_i),
    .lu_row_o           (lu_row_o),
    .lu_row_valid_o     (lu_row_valid_o),
    .lu_row_addr_o      (lu_row_addr_o),
    .lu_wr_row_i        (lu_wr_row_i),
    .lu_wr_valid_i      (lu_wr_valid_i),
    .lu_wr_addr_i       (lu_wr_addr_i),
    .lu_wr_ready_o      (lu_wr_ready_o)
  );

  always @(posedge clk_i) begin
    if (done_o)     done_seen++;
    if (lu_start_o) start_seen++;
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RW-1:0] grid_row(input int row);
    logic [RW-1:0] r;
    real v;
    for (int c = 0; c < SIZE; c++) begin
      v = real'(row*10 + c);
      r[c*2*WIDTH +: 2*WIDTH] = {$realtobits(-v), $realtobits(v)};
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] ones_row();
    logic [RW-1:0] r;
    for (int c = 0; c < SIZE; c++)
      r[c*2*WIDTH +: 2*WIDTH] = {$realtobits(1.0), $realtobits(1.0)};
    return r;
  endfunction

  task automatic idle_inputs();
    host_row_i = '0; host_row_valid_i = 0; host_start_i = 0; flush_i = 0;
    out_row_ready_i = 0; lu_busy_i = 0; lu_rd_addr_i = '0; lu_rd_addr_valid_i = 0;
    lu_wr_row_i = '0; lu_wr_valid_i = 0; lu_wr_addr_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   host_row_ready_o, 0);
    check({tag, "_ovalid"},  out_row_valid_o, 0);
    check({tag, "_done"},    done_o, 0);
    check({tag, "_start"},   lu_start_o, 0);
    check({tag, "_flush"},   lu_flush_o, 0);
    check({tag, "_rvalid"},  lu_row_valid_o, 0);
    check({tag, "_wready"},  lu_wr_ready_o, 0);
    check({tag, "_orow"},    out_row_o, 0);
    check({tag, "_lurow"},   lu_row_o, 0);
    check({tag, "_luaddr"},  lu_row_addr_o, 0);
  endtask

  // Host loads model[] with random valid gaps; ends in the first RUN cycle.
  task automatic load_model();
    int r = 0;
    int guard = 0;
    host_start_i = 1; step(); host_start_i = 0;
    check("load_ready", host_row_ready_o, 1);
    while (r < SIZE && guard < 40) begin
      host_row_valid_i = 1'($urandom_range(0, 1));
      host_row_i = host_row_valid_i ? model[r] : rand_row();
      step();
      if (host_row_valid_i) r++;
      guard++;
    end
    host_row_valid_i = 0;
    check("load_rows", r, SIZE);
    check("start_pulse", lu_start_o, 1);
    check("start_ready_off", host_row_ready_o, 0);
    step();
    check("start_once", lu_start_o, 0);
    check("run_wready", lu_wr_ready_o, 1);
  endtask

  // Random lu reads/writes plus ignored host traffic while busy.
  task automatic run_random(input int n);
    logic          rv, wv, exp_v;
    logic [AW-1:0] ra, wa;
    logic [RW-1:0] wd, exp_d;
    for (int i = 0; i < n; i++) begin
      lu_busy_i = 1;
      rv = 1'($urandom_range(0, 1)); ra = AW'($urandom_range(0, SIZE-1));
      wv = 1'($urandom_range(0, 1)); wa = AW'($urandom_range(0, SIZE-1));
      wd = rand_row();
      lu_rd_addr_valid_i = rv; lu_rd_addr_i = ra;
      lu_wr_valid_i = wv; lu_wr_addr_i = wa; lu_wr_row_i = wd;
      host_row_valid_i = 1'($urandom_range(0, 1)); host_row_i = rand_row();
      host_start_i = ($urandom_range(0, 7) == 0);
      exp_v = rv;
      exp_d = model[ra];
`ifdef LU_ROW_STORE_BYPASS_EN
      if (wv && wa == ra) exp_d = wd;
`endif
      if (wv) model[wa] = wd;
      step();
      check("rnd_rvalid", lu_row_valid_o, exp_v);
      check("rnd_hready", host_row_ready_o, 0);
      if (exp_v) begin
        check("rnd_rdata", lu_row_o, exp_d);
        check("rnd_raddr", lu_row_addr_o, ra);
      end
    end
    lu_rd_addr_valid_i = 0; lu_wr_valid_i = 0; host_row_valid_i = 0; host_start_i = 0;
  endtask

  // Busy for n_busy cycles, then drop busy with a final write that must still land.
  task automatic finish_run(input int n_busy);
    logic [AW-1:0] wa;
    lu_busy_i = 1;
    repeat (n_busy) begin
      step();
      check("busy_hold_run", lu_wr_ready_o, 1);
    end
    lu_busy_i = 0;
    wa = AW'($urandom_range(0, SIZE-1));
    lu_wr_valid_i = 1; lu_wr_addr_i = wa; lu_wr_row_i = rand_row();
    model[wa] = lu_wr_row_i;
    step();
    lu_wr_valid_i = 0;
    check("enter_drain", out_row_valid_o, 1);
    check("drain_wready", lu_wr_ready_o, 0);
  endtask

  task automatic drain(input int stall_row);
    int r = 0;
    int guard = 0;
    int stall = 0;
    while (r < SIZE && guard < 60) begin
      check("drain_valid", out_row_valid_o, 1);
      check("drain_data", out_row_o, model[r]);
      if (r == stall_row && stall < 3) begin
        out_row_ready_i = 0;
        stall++;
      end else begin
        out_row_ready_i = ($urandom_range(0, 3) != 0);
      end
      step();
      if (out_row_ready_i) r++;
      guard++;
    end
    out_row_ready_i = 0;
    check("drain_rows", r, SIZE);
    check("done_pulse", done_o, 1);
    check("drain_exit", out_row_valid_o, 0);
    step();
    check("done_once", done_o, 0);
  endtask

  initial begin
    idle_inputs();
    rst_ni = 0;
    step(); step();
    check_all_zero("rst");
    rst_ni = 1;
    step();

    // Host valid with no start is ignored.
    host_row_valid_i = 1; host_row_i = rand_row();
    repeat (3) begin
      step();
      check("idle_no_ready", host_row_ready_o, 0);
      check("idle_no_start", lu_start_o, 0);
    end
    host_row_valid_i = 0;

    // Reset in the middle of a load.
    host_start_i = 1; step(); host_start_i = 0;
    host_row_valid_i = 1;
    host_row_i = rand_row(); step();
    host_row_i = rand_row(); step();
    host_row_valid_i = 0;
    rst_ni = 0; #1;
    check_all_zero("mid_rst");
    step();
    rst_ni = 1;
    step();

    // Matrix real=row*10+col, imag=-real.
    for (int r = 0; r < SIZE; r++) model[r] = grid_row(r);
    load_model();
    lu_busy_i = 1;
    lu_rd_addr_valid_i = 1; lu_rd_addr_i = 3;
    step();
    check("rd3_valid", lu_row_valid_o, 1);
    check("rd3_addr", lu_row_addr_o, 3);
    check("rd3_data", lu_row_o, model[3]);
    lu_rd_addr_i = 0;
    step();
    check("rd0_valid", lu_row_valid_o, 1);
    check("rd0_addr", lu_row_addr_o, 0);
    check("rd0_data", lu_row_o, model[0]);

    // Same-address read and write in one cycle.
    lu_rd_addr_i = 1;
    lu_wr_valid_i = 1; lu_wr_addr_i = 1; lu_wr_row_i = ones_row();
    begin
      logic [RW-1:0] exp_same;
`ifdef LU_ROW_STORE_BYPASS_EN
      exp_same = ones_row();
`else
      exp_same = model[1];
`endif
      model[1] = ones_row();
      step();
      check("same_cycle_rd", lu_row_o, exp_same);
    end
    lu_wr_valid_i = 0;
    step();
    check("reread_ones", lu_row_o, ones_row());
    lu_rd_addr_valid_i = 0;

    run_random(30);
    finish_run(5);
    drain(2);

    // Flush during RUN.
    for (int r = 0; r < SIZE; r++) model[r] = rand_row();
    load_model();
    run_random(5);
    flush_i = 1; #1;
    check("flush_mirror", lu_flush_o, 1);
    step();
    flush_i = 0; #1;
    check("flush_one_cycle", lu_flush_o, 0);
    check("flush_idle_wready", lu_wr_ready_o, 0);
    check("flush_idle_ovalid", out_row_valid_o, 0);
    lu_rd_addr_valid_i = 1; lu_rd_addr_i = 2;
    lu_wr_valid_i = 1; lu_wr_addr_i = 2; lu_wr_row_i = rand_row();
    step();
    check("flush_rd_ignored", lu_row_valid_o, 0);
    check("flush_no_done", done_o, 0);
    idle_inputs();
    step();

    // Fresh round: busy must be seen before RUN can end.
    for (int r = 0; r < SIZE; r++) model[r] = rand_row();
    load_model();
    repeat (3) begin
      step();
      check("wait_busy", lu_wr_ready_o, 1);
    end
    run_random(20);
    finish_run(2);
    drain(SIZE);

    step();
    check("done_count", done_seen, 2);
    check("start_count", start_seen, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
